// File: rtl/apb_master_arbiter_if.sv
// Bus bundle for apb_master_arbiter: requester handshake on one side,
// APB master signals toward the register bridge on the other.
interface apb_master_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 19
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*32-1:0]     req_wdata;
  logic [NUM_REQ-1:0]        req_done;
  logic [31:0]               req_rdata;
  logic                      req_err;
  logic                      busy;

  logic [ADDR_W-1:0]         m_paddr;
  logic                      m_psel;
  logic                      m_penable;
  logic                      m_pwrite;
  logic [31:0]               m_pwdata;
  logic [31:0]               m_prdata;
  logic                      m_pready;

  modport master (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  m_prdata,
    input  m_pready,
    output req_done,
    output req_rdata,
    output req_err,
    output busy,
    output m_paddr,
    output m_psel,
    output m_penable,
    output m_pwrite,
    output m_pwdata
  );

  modport slave (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output m_prdata,
    output m_pready,
    input  req_done,
    input  req_rdata,
    input  req_err,
    input  busy,
    input  m_paddr,
    input  m_psel,
    input  m_penable,
    input  m_pwrite,
    input  m_pwdata
  );

endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master between NUM_REQ requesters.
// One transfer at a time; a bounded ACCESS phase keeps the bus from hanging.
module apb_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 19,
  parameter int TIMEOUT = 255
) (
  input  logic                 apb_clk,
  input  logic                 apb_rst,
  apb_master_arbiter_if.master bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int KW = IW + 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam int CW = TO_EN ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TO_EN ? TIMEOUT - 1 : 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] done_q, done_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] elig;
  logic [IW-1:0]      win;
  logic               found;
  logic [KW-1:0]      k;

  logic [ADDR_W-1:0]  w_addr;
  logic [31:0]        w_wdata;
  logic               w_write;

  // A requester whose done pulse is high this cycle is not re-granted
  // until its valid is re-sampled on the following cycle.
  always_comb begin
    elig  = bus.req_valid & ~done_q;
    win   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = {1'b0, ptr_q} + KW'(i);
      if (k >= KW'(NUM_REQ)) begin
        k = k - KW'(NUM_REQ);
      end
      if (!found && elig[k[IW-1:0]]) begin
        found = 1'b1;
        win   = k[IW-1:0];
      end
    end
  end

  assign w_addr  = bus.req_addr[win*ADDR_W +: ADDR_W];
  assign w_wdata = bus.req_wdata[win*32 +: 32];
  assign w_write = bus.req_write[win];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    busy_d    = busy_q;
    done_d    = '0;
    rdata_d   = '0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        busy_d    = 1'b0;
        if (found) begin
          state_d  = S_SETUP;
          win_d    = win;
          paddr_d  = w_addr;
          pwrite_d = w_write;
          pwdata_d = w_wdata;
          psel_d   = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = '0;
          if (win == IW'(NUM_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = win + 1'b1;
          end
        end
      end

      S_SETUP: begin
        state_d   = S_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
        busy_d    = 1'b1;
      end

      S_ACCESS: begin
        if (bus.m_pready) begin
          state_d       = S_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          busy_d        = 1'b0;
          done_d[win_q] = 1'b1;
          rdata_d       = pwrite_q ? 32'h0 : bus.m_prdata;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (TO_EN && cnt_q == CNT_LAST) begin
            state_d       = S_IDLE;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            busy_d        = 1'b0;
            done_d[win_q] = 1'b1;
            err_d         = 1'b1;
          end
        end
      end

      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign bus.req_done  = done_q;
  assign bus.req_rdata = rdata_q;
  assign bus.req_err   = err_q;
  assign bus.busy      = busy_q;
  assign bus.m_paddr   = paddr_q;
  assign bus.m_psel    = psel_q;
  assign bus.m_penable = penable_q;
  assign bus.m_pwrite  = pwrite_q;
  assign bus.m_pwdata  = pwdata_q;

endmodule
